board_input_cond: RTL

Input conditioner for the NEXYS4-DDR board top, sitting directly upstream of the `sigma` SoC instance. It takes the raw, asynchronous, bouncing centre button and slide switches. For each input it performs two-flop synchronization and tick-based debouncing. It drives:
- the debounced button into `irq_btn_i`,
- the debounced switch word into the SW field of `gpio_bi`,
- a one-cycle switch-change strobe for optional use by the board top.

---
 rtl/board_input_cond.sv | 112 +++++++++++
 1 files changed

// File: rtl/board_input_cond.sv
// Input conditioner: 2-flop synchronizers plus tick-based debounce for the centre button and slide switches.
// Optional build macro BOARD_INPUT_COND_BTN_PULSE_EN turns btn_o into a rising-edge pulse instead of a level.
module board_input_cond #(
    parameter int NUM_SW    = 16,
    parameter int TICK_DIV  = 100000,
    parameter int DEB_TICKS = 10
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              btn_i,
    input  logic [NUM_SW-1:0] sw_i,
    output logic              btn_o,
    output logic [NUM_SW-1:0] sw_o,
    output logic              sw_chg_o
);

    // Button rides in the top bit so one debounce loop covers every input.
    localparam int N  = NUM_SW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [N-1:0]  raw;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  deb;
    logic [N-1:0]  deb_nxt;
    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];
    logic [PW-1:0] pre;
    logic          tick;

    assign raw = {btn_i, sw_i};

    // Synchronizer stage
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler; input activity never restarts it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_LAST);

    // Any cycle back at the accepted level wipes the partial count, tick or not.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < N; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == deb[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick && (cnt[i] == CNT_LAST)) begin
                deb_nxt[i] = sync2[i];
                cnt_nxt[i] = '0;
            end else if (tick) begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Debounce stage
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            deb      <= '0;
            sw_chg_o <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb      <= deb_nxt;
            sw_chg_o <= |(deb_nxt[NUM_SW-1:0] ^ deb[NUM_SW-1:0]);
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign sw_o = deb[NUM_SW-1:0];

`ifdef BOARD_INPUT_COND_BTN_PULSE_EN
    logic btn_pulse;

    // Pulse lands on the same edge the debounced button rises.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= deb_nxt[NUM_SW] & ~deb[NUM_SW];
        end
    end

    assign btn_o = btn_pulse;
`else
    assign btn_o = deb[NUM_SW];
`endif

endmodule
